// File: rtl/dispense_sequencer.sv
// Fluid dispenser front-end sequencer.
// Handles one request at a time: check and debit the stock for the requested
// fluid, run the pump for TICKS_PER_L cycles per litre, then report the result
// with a one-cycle done pulse. Restocks can arrive in any state.
//
// Handshake: a request is taken on a rising edge where req_valid and req_ready
// are both high. req_ready depends only on the state and is high only in IDLE.
// There is no queueing: while a job is in flight req_ready stays low and any
// req_valid is ignored.
module dispense_sequencer #(
    parameter int STOCK_INIT  = 50,
    parameter int TICKS_PER_L = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  user_id,
    input  logic [1:0]  fluid_type,
    input  logic [7:0]  volume_l,
    input  logic        restock_valid,
    input  logic [1:0]  restock_type,
    input  logic [15:0] restock_qty,
    output logic        pump_en,
    output logic [1:0]  pump_sel,
    output logic [7:0]  litres_out,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [3:0]  done_user,
    output logic [15:0] remaining_qty
);

    localparam int TW = (TICKS_PER_L > 1) ? $clog2(TICKS_PER_L) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_PUMP   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_REJECT = 3'd4;

    logic [2:0]    state;
    logic [3:0]    job_user;
    logic [1:0]    job_type;
    logic [7:0]    job_vol;
    logic [1:0]    rej_status;
    logic [TW-1:0] tick;
    logic [15:0]   stock      [3];
    logic [15:0]   stock_base [3];
    logic [16:0]   stock_sum  [3];
    logic [15:0]   stock_next [3];
    logic [15:0]   sel_stock;
    logic          req_bad;
    logic          short_stock;
    logic          debit_ok;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign pump_en   = (state == S_PUMP);
    assign pump_sel  = pump_en ? job_type : 2'd0;

    // Stock of the latched fluid; the invalid code 11 has no stock and reads 0.
    always_comb begin
        sel_stock = 16'd0;
        case (job_type)
            2'd0:    sel_stock = stock[0];
            2'd1:    sel_stock = stock[1];
            2'd2:    sel_stock = stock[2];
            default: sel_stock = 16'd0;
        endcase
    end

    assign req_bad     = (job_type == 2'd3) || (job_vol == 8'd0);
    assign short_stock = ({8'd0, job_vol} > sel_stock);
    assign debit_ok    = (state == S_CHECK) && !req_bad && !short_stock;

    // Next stock per fluid: debit (judged on pre-restock stock) then saturating restock.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stock_base[i] = stock[i];
            if (debit_ok && (job_type == 2'(i)))
                stock_base[i] = stock[i] - {8'd0, job_vol};
            stock_sum[i]  = {1'b0, stock_base[i]} + {1'b0, restock_qty};
            stock_next[i] = stock_base[i];
            if (restock_valid && (restock_type == 2'(i)))
                stock_next[i] = stock_sum[i][16] ? 16'hFFFF : stock_sum[i][15:0];
        end
    end

    // Stock registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) stock[i] <= 16'(STOCK_INIT);
            else       stock[i] <= stock_next[i];
        end
    end

    // Job sequencing: accept, check, pump, report.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            job_user      <= 4'd0;
            job_type      <= 2'd0;
            job_vol       <= 8'd0;
            rej_status    <= 2'd0;
            tick          <= '0;
            litres_out    <= 8'd0;
            done          <= 1'b0;
            status        <= 2'd0;
            done_user     <= 4'd0;
            remaining_qty <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        job_user <= user_id;
                        job_type <= fluid_type;
                        job_vol  <= volume_l;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (req_bad) begin
                        rej_status <= 2'b10;
                        state      <= S_REJECT;
                    end else if (short_stock) begin
                        rej_status <= 2'b01;
                        state      <= S_REJECT;
                    end else begin
                        litres_out <= 8'd0;
                        tick       <= '0;
                        state      <= S_PUMP;
                    end
                end
                S_PUMP: begin
                    if (tick == TW'(TICKS_PER_L - 1)) begin
                        tick       <= '0;
                        litres_out <= litres_out + 8'd1;
                        if ((litres_out + 8'd1) == job_vol)
                            state <= S_DONE;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                S_DONE: begin
                    done          <= 1'b1;
                    status        <= 2'b00;
                    done_user     <= job_user;
                    remaining_qty <= sel_stock;
                    state         <= S_IDLE;
                end
                S_REJECT: begin
                    done          <= 1'b1;
                    status        <= rej_status;
                    done_user     <= job_user;
                    remaining_qty <= sel_stock;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
